// File: rtl/hermes_packet_injector.sv
// Hermes router local-port packet source: header, size and payload flits under credit flow control.
// Optional statistics counters are enabled by defining HERMES_INJECTOR_STATS_EN.
`timescale 1ns/1ps
module hermes_packet_injector #(
    parameter int unsigned FLIT_SIZE = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 pkt_valid_i,
    output logic                 pkt_ready_o,
    input  logic [15:0]          pkt_target_i,
    input  logic [15:0]          pkt_size_i,
    input  logic                 pl_valid_i,
    output logic                 pl_ready_o,
    input  logic [FLIT_SIZE-1:0] pl_data_i,
    output logic                 tx_o,
    input  logic                 credit_i,
    output logic [FLIT_SIZE-1:0] data_o,
    output logic                 busy_o,
    output logic                 done_o
`ifdef HERMES_INJECTOR_STATS_EN
    ,
    output logic [31:0]          pkt_cnt_o,
    output logic [31:0]          flit_cnt_o,
    output logic [31:0]          stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SIZE,
        S_PAYLOAD,
        S_DRAIN
    } state_e;

    state_e               state_q, state_d;
    logic                 tx_q, tx_d;
    logic [FLIT_SIZE-1:0] data_q, data_d;
    logic                 done_q, done_d;
    logic [15:0]          size_q, size_d;
    logic [15:0]          rem_q, rem_d;
    logic                 out_free;
    logic                 xfer;

    assign xfer        = tx_q && credit_i;
    assign out_free    = !tx_q || credit_i;
    assign pkt_ready_o = (state_q == S_IDLE);
    assign pl_ready_o  = (state_q == S_PAYLOAD) && out_free;
    assign tx_o        = tx_q;
    assign data_o      = data_q;
    assign done_o      = done_q;
    assign busy_o      = (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        size_d  = size_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        // A transferred flit frees the slot; any load below re-asserts tx.
        tx_d    = xfer ? 1'b0 : tx_q;
        unique case (state_q)
            S_IDLE: begin
                if (pkt_valid_i) begin
                    data_d  = {{(FLIT_SIZE-16){1'b0}}, pkt_target_i};
                    tx_d    = 1'b1;
                    size_d  = pkt_size_i;
                    state_d = S_SIZE;
                end
            end
            S_SIZE: begin
                if (out_free) begin
                    data_d  = {{(FLIT_SIZE-16){1'b0}}, size_q};
                    tx_d    = 1'b1;
                    rem_d   = size_q;
                    state_d = (size_q != 16'd0) ? S_PAYLOAD : S_DRAIN;
                end
            end
            S_PAYLOAD: begin
                if (pl_valid_i && out_free) begin
                    data_d = pl_data_i;
                    tx_d   = 1'b1;
                    rem_d  = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (xfer) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            tx_q    <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            size_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            data_q  <= data_d;
            done_q  <= done_d;
            size_q  <= size_d;
            rem_q   <= rem_d;
        end
    end

`ifdef HERMES_INJECTOR_STATS_EN
    logic [31:0] pkt_cnt_q, flit_cnt_q, stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pkt_cnt_q   <= '0;
            flit_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (done_q)           pkt_cnt_q   <= pkt_cnt_q + 32'd1;
            if (xfer)             flit_cnt_q  <= flit_cnt_q + 32'd1;
            if (tx_q && !credit_i) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign pkt_cnt_o   = pkt_cnt_q;
    assign flit_cnt_o  = flit_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
